// File: rtl/unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// unidade_controle_rodadas
//
// Moore control unit for the multi-round memory game. It sequences the
// datapath (address counter E, round-limit counter L, play register R and
// comparator). Round N asks the player to repeat positions 0..N. The game is
// won after the last round, and lost on a mismatch or on a per-play timeout.
//
// Optional feature, macro TIMEOUT_EN:
//   defined   -> an internal counter limits the time spent in ESPERA to
//                TIMEOUT_CICLOS cycles and the TIMEOUT state becomes reachable.
//   undefined -> no counter, ESPERA waits forever, timeout is tied to 0.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low; forces INICIAL and clears outputs
//   iniciar    start / restart request (level)
//   jogada     one-cycle pulse: a play was made
//   igual      registered play equals the memory word
//   fimE       address counter equals the current round limit
//   fimL       round-limit counter is at the last round
//   zeraE, contaE, zeraL, contaL, zeraR, registraR   datapath controls
//   acertou, errou, timeout, pronto                   game outcome
//   db_estado  current state code, for the 7-segment debug display
// -----------------------------------------------------------------------------
module unidade_controle_rodadas #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMO        = 4'h6,
    FIM_RODADA     = 4'h7,
    PROXIMA_RODADA = 4'h8,
    ACERTOU        = 4'hC,
    ERROU          = 4'hD,
    TIMEOUT        = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic acertou;
    logic errou;
    logic timeout;
    logic pronto;
  } saidas_t;

  estado_t estado;
  estado_t proximo;
  saidas_t saidas_q;
  logic    estourou;

  // Output pattern of each state; the only place the Moore table lives.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zera_e = 1'b1;
        s.zera_l = 1'b1;
        s.zera_r = 1'b1;
      end
      INICIO_RODADA:  s.zera_e     = 1'b1;
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMO:        s.conta_e    = 1'b1;
      PROXIMA_RODADA: s.conta_l    = 1'b1;
      ACERTOU: begin
        s.acertou = 1'b1;
        s.pronto  = 1'b1;
      end
      ERROU: begin
        s.errou  = 1'b1;
        s.pronto = 1'b1;
      end
      TIMEOUT: begin
`ifdef TIMEOUT_EN
        s.timeout = 1'b1;
`endif
        s.pronto  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

`ifdef TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [CW-1:0] contador;

  // Fires on the TIMEOUT_CICLOS-th edge spent in ESPERA (count starts at 0).
  assign estourou = (contador == CW'(TIMEOUT_CICLOS - 1));

  // Any state other than ESPERA clears the count, so re-entering ESPERA
  // through PROXIMO always starts a fresh timeout window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else if (estado == ESPERA) begin
      contador <= contador + CW'(1);
    end else begin
      contador <= '0;
    end
  end
`else
  // No timeout hardware in this build; TIMEOUT_CICLOS only takes part in this
  // elaboration-time condition, which never creates logic.
  assign estourou = 1'b0;
  if (TIMEOUT_CICLOS < 2) begin : g_timeout_ciclos_ignorado
  end
`endif

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:        if (iniciar) proximo = PREPARA;
      PREPARA:        proximo = INICIO_RODADA;
      INICIO_RODADA:  proximo = ESPERA;
      ESPERA: begin
        // A play in the same cycle as the timeout wins.
        if (jogada)        proximo = REGISTRA;
        else if (estourou) proximo = TIMEOUT;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!igual)     proximo = ERROU;
        else if (fimE)  proximo = FIM_RODADA;
        else            proximo = PROXIMO;
      end
      PROXIMO:        proximo = ESPERA;
      FIM_RODADA:     proximo = fimL ? ACERTOU : PROXIMA_RODADA;
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      ACERTOU, ERROU, TIMEOUT: if (iniciar) proximo = PREPARA;
      default:        proximo = INICIAL;
    endcase
  end

  // Outputs are registered from the decoded next state, so they change on
  // the same edge as the state and never see the inputs combinationally.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado   <= proximo;
      saidas_q <= decodifica(proximo);
    end
  end

  assign zeraE     = saidas_q.zera_e;
  assign contaE    = saidas_q.conta_e;
  assign zeraL     = saidas_q.zera_l;
  assign contaL    = saidas_q.conta_l;
  assign zeraR     = saidas_q.zera_r;
  assign registraR = saidas_q.registra_r;
  assign acertou   = saidas_q.acertou;
  assign errou     = saidas_q.errou;
  assign timeout   = saidas_q.timeout;
  assign pronto    = saidas_q.pronto;
  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// Testbench for unidade_controle_rodadas.
//
// Games are described at the level of the player: number of rounds, which
// play (if any) mismatches, which play (if any) is left to time out. From that
// description the bench derives, edge by edge, which state code the control
// unit must show; a compare process checks db_estado and every output against
// that expectation on each falling edge. Literal checks pin the expectations
// of the hand-worked scenarios.
// -----------------------------------------------------------------------------
module tb_unidade_controle_rodadas;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada, igual, fimE, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_code  = 4'h0;
  bit         exp_valid = 1'b0;

  int cnt_ze = 0, cnt_zl = 0, cnt_zr = 0, cnt_cl = 0;

  unidade_controle_rodadas #(.TIMEOUT_CICLOS(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimE      (fimE),
    .fimL      (fimL),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .zeraL     (zeraL),
    .contaL    (contaL),
    .zeraR     (zeraR),
    .registraR (registraR),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  wire [9:0] saidas = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                       acertou, errou, timeout, pronto};

  task automatic check(input string nome, input logic [15:0] got,
                       input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, want, $time);
    end
  endtask

  // What each visible state code must drive, bit order as in 'saidas'.
  function automatic logic [9:0] outs_for(input logic [3:0] c);
    case (c)
      4'h1:    return 10'b1010100000;
      4'h2:    return 10'b1000000000;
      4'h4:    return 10'b0000010000;
      4'h6:    return 10'b0100000000;
      4'h8:    return 10'b0001000000;
      4'hC:    return 10'b0000001001;
      4'hD:    return 10'b0000000101;
      4'hE:    return 10'b0000000011;
      default: return 10'b0000000000;
    endcase
  endfunction

  // Single compare process.
  always @(negedge clock) begin
    if (exp_valid) begin
      check("db_estado", {12'h0, db_estado}, {12'h0, exp_code});
      check("saidas", {6'h0, saidas}, {6'h0, outs_for(exp_code)});
    end
    if (zeraE)  cnt_ze++;
    if (zeraL)  cnt_zl++;
    if (zeraR)  cnt_zr++;
    if (contaL) cnt_cl++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Wait for the next rising edge and declare the state code it must produce.
  task automatic cyc(input logic [3:0] exp);
    @(posedge clock);
    #1;
    exp_code = exp;
  endtask

  // Inputs that the current state ignores get random values.
  task automatic noise();
    iniciar = 1'($urandom);
    igual   = 1'($urandom);
    fimE    = 1'($urandom);
    fimL    = 1'($urandom);
  endtask

  // Plays one game from INICIAL or a terminal state. bad_r/bad_p: the play
  // that mismatches; to_r/to_p: the play left to time out; -1 for none.
  // force_idle >= 0 fixes the idle cycles before every play.
  task automatic run_game(input int rounds, input int bad_r, input int bad_p,
                          input int to_r, input int to_p, input int force_idle,
                          output logic [3:0] fim);
    int idle;
    fim = 4'h0;
    noise(); jogada = 1'b0; iniciar = 1'b1; cyc(4'h1);
    noise(); cyc(4'h2);
    noise(); cyc(4'h3);
    for (int r = 0; r < rounds; r++) begin
      for (int p = 0; p <= r; p++) begin
        idle = (force_idle >= 0) ? force_idle : int'($urandom_range(0, 4));
        if (r == to_r && p == to_p) begin
`ifdef TIMEOUT_EN
          for (int k = 1; k < TO; k++) begin noise(); cyc(4'h3); end
          noise(); cyc(4'hE);
          fim = 4'hE;
          return;
`else
          idle = 100;
`endif
        end
        for (int k = 0; k < idle; k++) begin noise(); cyc(4'h3); end
        noise(); jogada = 1'b1; cyc(4'h4);
        noise(); jogada = 1'b0; cyc(4'h5);
        noise();
        igual = !(r == bad_r && p == bad_p);
        fimE  = (p == r);
        if (!igual) begin
          cyc(4'hD);
          fim = 4'hD;
          return;
        end
        if (p != r) begin
          cyc(4'h6);
          noise(); cyc(4'h3);
        end else begin
          cyc(4'h7);
          noise(); fimL = (r == rounds - 1);
          if (fimL) begin
            cyc(4'hC);
            fim = 4'hC;
            return;
          end
          cyc(4'h8);
          noise(); cyc(4'h2);
          noise(); cyc(4'h3);
        end
      end
    end
  endtask

  task automatic hold_terminal(input logic [3:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      noise(); iniciar = 1'b0; jogada = 1'($urandom); cyc(code);
    end
    jogada = 1'b0;
  endtask

  initial begin
    logic [3:0] fim;
    int rounds, br, bp, tr, tp;

    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0;
    igual = 1'b0; fimE = 1'b0; fimL = 1'b0;
    #12;
    check("reset_db_estado", {12'h0, db_estado}, 16'h0);
    check("reset_saidas", {6'h0, saidas}, 16'h0);

    @(posedge clock); #1;
    reset = 1'b1; exp_code = 4'h0; exp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      noise(); iniciar = 1'b0; jogada = 1'($urandom); cyc(4'h0);
    end
    jogada = 1'b0;

    // Two-round winning game.
    cnt_ze = 0; cnt_zl = 0; cnt_zr = 0; cnt_cl = 0;
    run_game(2, -1, -1, -1, -1, -1, fim);
    check("win_fim", {12'h0, fim}, 16'hC);
    check("win_zeraE_cycles", 16'(cnt_ze), 16'd3);
    check("win_zeraL_cycles", 16'(cnt_zl), 16'd1);
    check("win_zeraR_cycles", 16'(cnt_zr), 16'd1);
    check("win_contaL_cycles", 16'(cnt_cl), 16'd1);
    hold_terminal(4'hC, 5);
    check("win_acertou_pronto", {14'h0, acertou, pronto}, 16'h3);

    // First play mismatches: 3,4,5,D.
    run_game(3, 0, 0, -1, -1, 0, fim);
    check("mismatch_db_estado", {12'h0, db_estado}, 16'hD);
    check("mismatch_flags", {13'h0, errou, pronto, acertou}, 16'h6);
    hold_terminal(4'hD, 3);

    // Restart from ERROU without reset.
    noise(); iniciar = 1'b1; cyc(4'h1);
    check("restart_zeras", {13'h0, zeraE, zeraL, zeraR}, 16'h7);
    noise(); cyc(4'h2);
    noise(); cyc(4'h3);
    noise(); jogada = 1'b1; cyc(4'h4);
    noise(); jogada = 1'b0; cyc(4'h5);
    noise(); igual = 1'b0; cyc(4'hD);
    hold_terminal(4'hD, 2);

`ifdef TIMEOUT_EN
    run_game(3, -1, -1, 0, 0, -1, fim);
    check("timeout_db_estado", {12'h0, db_estado}, 16'hE);
    check("timeout_flag", {15'h0, timeout}, 16'h1);
    hold_terminal(4'hE, 3);
    // Play arrives on the last allowed cycle: REGISTRA wins over TIMEOUT.
    run_game(2, -1, -1, -1, -1, TO - 1, fim);
    check("late_play_fim", {12'h0, fim}, 16'hC);
    hold_terminal(fim, 2);
`else
    run_game(1, -1, -1, 0, 0, -1, fim);
    check("no_timeout_fim", {12'h0, fim}, 16'hC);
    check("no_timeout_flag", {15'h0, timeout}, 16'h0);
    hold_terminal(fim, 2);
`endif

    // Asynchronous reset while in COMPARA.
    noise(); iniciar = 1'b1; cyc(4'h1);
    noise(); cyc(4'h2);
    noise(); cyc(4'h3);
    noise(); jogada = 1'b1; cyc(4'h4);
    noise(); jogada = 1'b0; cyc(4'h5);
    check("pre_reset_compara", {12'h0, db_estado}, 16'h5);
    exp_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset_db_estado", {12'h0, db_estado}, 16'h0);
    check("async_reset_saidas", {6'h0, saidas}, 16'h0);
    iniciar = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; exp_code = 4'h0; exp_valid = 1'b1;
    noise(); iniciar = 1'b0; cyc(4'h0);

    // Randomized games.
    for (int g = 0; g < 25; g++) begin
      rounds = int'($urandom_range(1, 4));
      br = -1; bp = -1; tr = -1; tp = -1;
      if ($urandom_range(0, 2) == 0) begin
        br = int'($urandom_range(0, rounds - 1));
        bp = int'($urandom_range(0, br));
      end
      if ($urandom_range(0, 3) == 0) begin
        tr = int'($urandom_range(0, rounds - 1));
        tp = int'($urandom_range(0, tr));
      end
      run_game(rounds, br, bp, tr, tp, -1, fim);
      hold_terminal(fim, int'($urandom_range(1, 3)));
    end

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
- Moore FSM sequencing the memory-game datapath (address counter, round-limit counter, play register, comparator) for the multi-round game.
- Round N requires the player to repeat sequence positions 0..N. The game is won after the last round, and lost on a mismatch or a per-play timeout.
- Sits beside the datapath inside the top-level circuit. Its state code drives a 7-segment debug display.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA before declaring timeout (>=2). Counter width is $clog2(TIMEOUT_CICLOS).

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces INICIAL immediately
- iniciar  in  1  start/restart request, level-sampled
- jogada  in  1  one-cycle pulse from datapath: a play was made
- igual  in  1  comparator: registered play equals memory word
- fimE  in  1  address counter equals current round limit
- fimL  in  1  round-limit counter at last round
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- zeraL  out  1  clear round-limit counter
- contaL  out  1  increment round-limit counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register
- acertou  out  1  game won
- errou  out  1  game lost by mismatch
- timeout  out  1  game lost by timeout
- pronto  out  1  game finished (any outcome)
- db_estado  out  4  current state code

Behaviour:
- Interface (already decided): one clock `clock`; `reset` is asynchronous and active-low.
- Outputs: all outputs decode from the state register only (Moore). No output depends combinationally on inputs.
- State codes (hex):
  - 0 INICIAL
  - 1 PREPARA
  - 2 INICIO_RODADA
  - 3 ESPERA
  - 4 REGISTRA
  - 5 COMPARA
  - 6 PROXIMO
  - 7 FIM_RODADA
  - 8 PROXIMA_RODADA
  - C ACERTOU
  - D ERROU
  - E TIMEOUT
- Reset: state=INICIAL and all outputs 0, including db_estado=0.
- Transitions:
  - INICIAL: iniciar=1 -> PREPARA, else stay.
  - PREPARA: assert zeraE, zeraL, zeraR -> INICIO_RODADA.
  - INICIO_RODADA: assert zeraE -> ESPERA.
  - ESPERA: jogada=1 -> REGISTRA; else internal timeout reached -> TIMEOUT; else stay. jogada has priority over timeout in the same cycle.
  - REGISTRA: assert registraR -> COMPARA.
  - COMPARA: igual=0 -> ERROU; igual=1 and fimE=1 -> FIM_RODADA; igual=1 and fimE=0 -> PROXIMO.
  - PROXIMO: assert contaE -> ESPERA.
  - FIM_RODADA: fimL=1 -> ACERTOU, else PROXIMA_RODADA.
  - PROXIMA_RODADA: assert contaL -> INICIO_RODADA.
  - ACERTOU: pronto=1, acertou=1.
  - ERROU: pronto=1, errou=1.
  - TIMEOUT: pronto=1, timeout=1.
  - Any terminal state: iniciar=1 -> PREPARA (restart without reset), else stay.
  - Unused codes (9,A,B,F): db_estado shows the raw code; next state INICIAL.
- Timeout counter:
  - Internal; cleared in every state except ESPERA; increments each cycle in ESPERA.
  - Timeout fires when count==TIMEOUT_CICLOS-1 with jogada=0, so TIMEOUT is entered exactly TIMEOUT_CICLOS cycles after entering ESPERA.
  - Re-entering ESPERA via PROXIMO restarts the count from 0.
- Latency:
  - iniciar to zeraE/zeraL/zeraR: 1 edge.
  - jogada to registraR: 1 edge.
  - registraR to outcome decision: 1 edge (COMPARA).
- Reset mid-operation: asynchronous return to INICIAL, timeout counter cleared, outputs 0 without waiting for a clock edge.
- iniciar held high through a terminal state restarts once per terminal visit. It has no effect in non-terminal states.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined: the timeout counter and TIMEOUT state are as described above.
- Undefined:
  - No counter is instantiated.
  - ESPERA waits indefinitely for jogada.
  - timeout output is tied 0 and state E is unreachable.
  - TIMEOUT_CICLOS is ignored.

Test Plan:
- Reset low then high, no iniciar for 10 cycles -> db_estado=0 and all outputs 0 throughout.
- Winning game, TIMEOUT_CICLOS=10, 2 rounds: pulse iniciar, then per play give jogada with igual=1; fimE=1 on last position of each round; fimL=1 in round 2. Required:
  - zeraE, zeraL, zeraR each pulse for 1 cycle.
  - contaL pulses once.
  - Final db_estado=C with acertou=1 and pronto=1, held until iniciar.
- Mismatch: first play with igual=0 -> db_estado sequence 3,4,5,D; errou=1, pronto=1; acertou=0.
- Timeout (TIMEOUT_EN defined, TIMEOUT_CICLOS=10): no jogada after entering ESPERA -> db_estado=E exactly 10 cycles later, timeout=1. Then jogada on cycle 10 instead -> REGISTRA, not TIMEOUT. Without TIMEOUT_EN: stays at 3 for 100 cycles.
- Restart and reset: iniciar=1 in state D -> next state 1 with zeraE/zeraL/zeraR asserted. Reset low while in COMPARA -> immediate db_estado=0 before the next clock edge.
